shift_deser: RTL and testbench

- Serial-to-parallel receiver, the inverse of the team's parallel-load shift register.
- Accepts one serial bit per qualified strobe and assembles WIDTH-bit words in either shift direction.
- Presents each completed word on a valid/ready parallel output with sticky error flags.
- Sits at the serial link endpoint and feeds downstream register/datapath logic.

---
 rtl/shift_deser_pkg.sv | 33 +++
 rtl/deser_shift_core.sv | 35 +++
 rtl/shift_deser.sv | 182 ++++++++++++++++++
 tb/tb_shift_deser.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deser_pkg.sv
// Shared definitions for the serial-to-parallel receiver: FSM states, direction codes, counter sizing.
// Latency: none (declarations only).
// Backpressure: n/a. The PAR state exists only when SHIFT_DESER_PARITY_EN is defined.
package shift_deser_pkg;

`ifdef SHIFT_DESER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      PAR  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1
   } state_t;
`endif

   // Bit order codes, as seen on lrshift
   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

   // Smallest r with 2**r >= value; used to size the bit counter
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/deser_shift_core.sv
// WIDTH-bit serial-in shift register with enable, clear and per-shift direction.
// Latency: one clock from en to updated q.
// Backpressure: none; shifts whenever en is high. clr together with en starts from an empty register.
module deser_shift_core
   import shift_deser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             dir,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] shifted;

   // Shift from the current contents, or from zero when the word is being restarted
   always_comb begin
      base = clr ? '0 : q;
      if (dir == DIR_MSB) shifted = {base[WIDTH-2:0], sin};
      else                shifted = {sin, base[WIDTH-1:1]};
   end

   // Register update: shift takes priority, a lone clear empties the register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    q <= '0;
      else if (en)  q <= shifted;
      else if (clr) q <= '0;
   end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words (MSB- or LSB-first) from strobed bits; optional even parity via SHIFT_DESER_PARITY_EN.
// Latency: dout_valid rises the cycle after the edge that samples the last bit (data bit WIDTH, or the parity bit).
// Backpressure: valid/ready output; a word completing while an unconsumed word is held is dropped and sets sticky overrun.
module shift_deser
   import shift_deser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             S,
   input  logic             bit_en,
   input  logic             frame_start,
   input  logic             lrshift,
   input  logic             dout_ready,
   input  logic             clr_err,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err,
   output logic             parity_err
);

   localparam int CW = clog2(WIDTH + 1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nx;
   logic             dir_q;
   logic             dir_nx;

   logic             shift_en;
   logic             shift_clr;
   logic             shift_dir;
   logic [WIDTH-1:0] core_q;

   logic             deliver;
   logic [WIDTH-1:0] word;
   logic             frame_err_set;
   logic             overrun_set;

`ifdef SHIFT_DESER_PARITY_EN
   logic             parity_err_set;
`else
   logic [WIDTH-1:0] last_word;

   // The final data bit is delivered on the edge that samples it, so the
   // completed word is formed here rather than taken from the register.
   always_comb begin
      if (dir_q == DIR_MSB) last_word = {core_q[WIDTH-2:0], S};
      else                  last_word = {S, core_q[WIDTH-1:1]};
   end
`endif

   deser_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .reset (reset),
      .en    (shift_en),
      .clr   (shift_clr),
      .dir   (shift_dir),
      .sin   (S),
      .q     (core_q)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state, shifter control, delivery request and error events
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      dir_nx        = dir_q;
      shift_en      = 1'b0;
      shift_clr     = 1'b0;
      shift_dir     = dir_q;
      deliver       = 1'b0;
      word          = core_q;
      frame_err_set = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      parity_err_set = 1'b0;
`endif
      if (bit_en) begin
         if (frame_start) begin
            // New word from any state; an unfinished one is abandoned and flagged
            shift_en      = 1'b1;
            shift_clr     = 1'b1;
            shift_dir     = lrshift;
            dir_nx        = lrshift;
            cnt_nx        = CW'(1);
            state_nx      = RECV;
            frame_err_set = (state != IDLE);
         end else begin
            case (state)
               RECV: begin
                  shift_en = 1'b1;
                  if (cnt == CW'(WIDTH - 1)) begin
`ifdef SHIFT_DESER_PARITY_EN
                     state_nx = PAR;
                     cnt_nx   = CW'(WIDTH);
`else
                     state_nx = IDLE;
                     cnt_nx   = '0;
                     deliver  = 1'b1;
                     word     = last_word;
`endif
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end
`ifdef SHIFT_DESER_PARITY_EN
               PAR: begin
                  // Parity bit: not shifted in; even parity over data plus this bit
                  state_nx       = IDLE;
                  cnt_nx         = '0;
                  deliver        = 1'b1;
                  word           = core_q;
                  parity_err_set = ^{core_q, S};
               end
`endif
               default: begin
                  // Strobes outside a frame carry no data
               end
            endcase
         end
      end
   end

   // Bit counter and latched bit order
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         dir_q <= DIR_LSB;
      end else begin
         cnt   <= cnt_nx;
         dir_q <= dir_nx;
      end
   end

   assign overrun_set = deliver && dout_valid && !dout_ready;

   // Output holding register: load when empty or being drained, otherwise hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (deliver && (!dout_valid || dout_ready)) begin
         dout       <= word;
         dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

   // Sticky error flags; a new event wins over a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= overrun_set   | (overrun   & ~clr_err);
         frame_err <= frame_err_set | (frame_err & ~clr_err);
      end
   end

`ifdef SHIFT_DESER_PARITY_EN
   // Sticky parity flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) parity_err <= 1'b0;
      else       parity_err <= parity_err_set | (parity_err & ~clr_err);
   end
`else
   assign parity_err = 1'b0;
`endif

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: directed scenarios followed by random traffic against a frame-level model.
// Latency: expects dout_valid the cycle after the last sampled bit.
// Backpressure: exercises dout_ready stalls, overrun and sticky flag clearing.
module tb_shift_deser;

   localparam int W = 8;
`ifdef SHIFT_DESER_PARITY_EN
   localparam bit PARITY = 1'b1;
`else
   localparam bit PARITY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         S;
   logic         bit_en;
   logic         frame_start;
   logic         lrshift;
   logic         dout_ready;
   logic         clr_err;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         busy;
   logic         overrun;
   logic         frame_err;
   logic         parity_err;

   int checks   = 0;
   int failures = 0;
   string phase = "reset";

   // Reference model state: bits of the current frame in arrival order
   logic         bits_q[$];
   logic         m_busy;
   logic         m_dir;
   logic [W-1:0] m_dout;
   logic         m_valid;
   logic         m_ovr;
   logic         m_ferr;
   logic         m_perr;

   always #5 clk = ~clk;

   shift_deser #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .S           (S),
      .bit_en      (bit_en),
      .frame_start (frame_start),
      .lrshift     (lrshift),
      .dout_ready  (dout_ready),
      .clr_err     (clr_err),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .busy        (busy),
      .overrun     (overrun),
      .frame_err   (frame_err),
      .parity_err  (parity_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check({phase, ".dout"},       32'(dout),   32'(m_dout));
      check({phase, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
      check({phase, ".busy"},       32'(busy),       32'(m_busy));
      check({phase, ".overrun"},    32'(overrun),    32'(m_ovr));
      check({phase, ".frame_err"},  32'(frame_err),  32'(m_ferr));
      check({phase, ".parity_err"}, 32'(parity_err), 32'(m_perr));
   endtask

   task automatic model_reset();
      bits_q.delete();
      m_busy  = 1'b0;
      m_dir   = 1'b0;
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
      m_perr  = 1'b0;
   endtask

   // Word value from the received bits: first bit lands at MSB (MSB-first) or LSB (LSB-first)
   function automatic logic [W-1:0] assemble();
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (m_dir) w[W-1-i] = bits_q[i];
         else       w[i]     = bits_q[i];
      end
      return w;
   endfunction

   function automatic logic ones_odd();
      int n;
      n = 0;
      for (int i = 0; i < bits_q.size(); i++) n += int'(bits_q[i]);
      return logic'(n % 2);
   endfunction

   // One clock: drive inputs, advance the model over the edge, compare after it
   task automatic cyc(input logic s, input logic en, input logic fs, input logic lr,
                      input logic rdy, input logic clr);
      logic         deliver;
      logic         f_set;
      logic         p_set;
      logic         o_set;
      logic [W-1:0] w;
      S = s; bit_en = en; frame_start = fs; lrshift = lr; dout_ready = rdy; clr_err = clr;
      deliver = 1'b0; f_set = 1'b0; p_set = 1'b0; o_set = 1'b0; w = '0;
      if (en) begin
         if (fs) begin
            f_set = m_busy;
            bits_q.delete();
            bits_q.push_back(s);
            m_dir  = lr;
            m_busy = 1'b1;
         end else if (m_busy) begin
            if (bits_q.size() == W) begin
               p_set   = ones_odd() ^ s;
               deliver = 1'b1;
            end else begin
               bits_q.push_back(s);
               if (bits_q.size() == W && !PARITY) deliver = 1'b1;
            end
            if (deliver) begin
               w      = assemble();
               m_busy = 1'b0;
               bits_q.delete();
            end
         end
      end
      if (deliver) begin
         if (!m_valid || rdy) begin
            m_dout  = w;
            m_valid = 1'b1;
         end else begin
            o_set = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      m_ovr  = o_set | (m_ovr  & ~clr);
      m_ferr = f_set | (m_ferr & ~clr);
      m_perr = p_set | (m_perr & ~clr);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input logic rdy, input logic clr);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy, clr);
   endtask

   // Full frame, transmitted from tx[W-1] down; optional lrshift toggling after bit 1
   task automatic send_frame(input logic [W-1:0] tx, input logic lr, input logic toggle,
                             input logic rdy, input logic clr_first);
      logic [W-1:0] v;
      v = tx;
      for (int i = 0; i < W; i++) begin
         cyc(v[W-1-i], 1'b1, (i == 0), toggle ? (lr ^ logic'(i % 2)) : lr, rdy,
             (i == 0) ? clr_first : 1'b0);
      end
`ifdef SHIFT_DESER_PARITY_EN
      cyc(^v, 1'b1, 1'b0, lr, rdy, 1'b0);
`endif
   endtask

   initial begin
      reset = 1'b1; S = 1'b0; bit_en = 1'b0; frame_start = 1'b0;
      lrshift = 1'b0; dout_ready = 1'b0; clr_err = 1'b0;
      model_reset();
      #1;
      check_all();
      #2 reset = 1'b0;

      phase = "msb";
      send_frame(8'hB2, 1'b1, 1'b0, 1'b1, 1'b0);
      check("msb.word", 32'(dout), 32'h0000_00B2);
      check("msb.valid", 32'(dout_valid), 32'd1);
      check("msb.busy_after", 32'(busy), 32'd0);
      idle(1'b1, 1'b0);

      phase = "lsb_toggle";
      send_frame(8'hB2, 1'b0, 1'b1, 1'b1, 1'b0);
      check("lsb.word", 32'(dout), 32'h0000_004D);
      idle(1'b1, 1'b0);

      phase = "backpressure";
      send_frame(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      check("bp.word_kept", 32'(dout), 32'h0000_00B2);
      check("bp.overrun", 32'(overrun), 32'd1);
      idle(1'b1, 1'b0);
      check("bp.drained", 32'(dout_valid), 32'd0);
      idle(1'b0, 1'b1);
      check("bp.cleared", 32'(overrun), 32'd0);

      phase = "restart";
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
      check("restart.frame_err", 32'(frame_err), 32'd1);
      check("restart.word", 32'(dout), 32'h0000_005A);
      idle(1'b1, 1'b1);
      check("restart.cleared", 32'(frame_err), 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
      check("restart.set_wins", 32'(frame_err), 32'd1);
      check("restart.word2", 32'(dout), 32'h0000_003C);
      idle(1'b1, 1'b1);

      phase = "reset_mid";
      for (int i = 0; i < 5; i++) cyc(logic'(i % 2), 1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
      check("reset_mid.word", 32'(dout), 32'h0000_00C3);
      idle(1'b1, 1'b0);

`ifdef SHIFT_DESER_PARITY_EN
      phase = "parity";
      send_frame(8'hB2, 1'b1, 1'b0, 1'b1, 1'b0);
      check("parity.good_flag", 32'(parity_err), 32'd0);
      check("parity.good_word", 32'(dout), 32'h0000_00B2);
      idle(1'b1, 1'b0);
      for (int i = 0; i < W; i++) begin
         logic [W-1:0] v;
         v = 8'hB2;
         cyc(v[W-1-i], 1'b1, (i == 0), 1'b1, 1'b1, 1'b0);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      check("parity.bad_flag", 32'(parity_err), 32'd1);
      check("parity.bad_word", 32'(dout), 32'h0000_00B2);
      idle(1'b1, 1'b1);
`endif

      phase = "random";
      for (int n = 0; n < 800; n++) begin
         logic en;
         logic fs;
         en = ($urandom_range(0, 3) != 0);
         fs = en && (m_busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0));
         cyc(logic'($urandom_range(0, 1)), en, fs, logic'($urandom_range(0, 1)),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
